sprite_row_renderer: RTL and testbench

Parametrised successor to the single-bitmap invader row drawer. Streams one row of up to N_SPRITES identical, integer-scaled sprites against the VGA horizontal scan, with per-sprite visibility, multiple animation frames and a run-time bitmap write port. It sits between game state (row position, alive mask, frame select) and the pixel colour mux. It outputs a registered 1-based index of the sprite whose lit pixel is being drawn.

---
 rtl/sprite_row_renderer.sv | 237 +++++++++++++++++++++++
 tb/tb_sprite_row_renderer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_row_renderer.sv
`timescale 1ns/1ps
// sprite_row_renderer
// Streams one row of up to N_SPRITES identical, integer-scaled sprites against
// the horizontal scan. Per-sprite visibility, FRAMES animation frames and a
// run-time bitmap write port.
//
// Optional feature macro: SPRITE_ROW_MIRROR_EN
//   defined   : mirror is latched at start and reverses column order
//   undefined : mirror is ignored, columns always drawn left-to-right
//
// Ports
//   clk, rst_n          pixel clock, async active-low reset
//   start               begin a row (ignored while busy)
//   frame, mirror       frame select / horizontal flip, latched at start
//   spr_x, mask         row left edge / per-sprite enable, latched at start
//   pixel_x             current scan column
//   wr_en/frame/row/data bitmap write port (bit SPR_W-1 = leftmost pixel)
//   spr_draw            0 = no pixel, k = lit pixel of sprite k-1 (registered)
//   busy, done          row in progress / one-cycle completion pulse
module sprite_row_renderer #(
  parameter int unsigned N_SPRITES = 11,
  parameter int unsigned SPR_W     = 13,
  parameter int unsigned SPR_H     = 8,
  parameter int unsigned SCALE     = 3,
  parameter int unsigned PITCH     = 16 * SCALE,
  parameter int unsigned FRAMES    = 2,
  parameter int unsigned PX_W      = 10,
  parameter int unsigned H_ACTIVE  = 640,
  localparam int unsigned FRM_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned ROW_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1,
  localparam int unsigned IDX_W    = $clog2(N_SPRITES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [FRM_W-1:0]     frame,
  input  logic                 mirror,
  input  logic [PX_W-1:0]      spr_x,
  input  logic [N_SPRITES-1:0] mask,
  input  logic [PX_W-1:0]      pixel_x,
  input  logic                 wr_en,
  input  logic [FRM_W-1:0]     wr_frame,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [SPR_W-1:0]     wr_data,
  output logic [IDX_W-1:0]     spr_draw,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned X_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned C_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned POS_W = PX_W + $clog2(N_SPRITES) + 1;
  localparam int unsigned SPAN  = SPR_W * SCALE;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEEK, S_DRAW, S_NEXT_LINE, S_DONE
  } state_t;

  state_t                 state_q, state_n;
  logic [FRM_W-1:0]       frame_q, frame_n;
  logic [PX_W-1:0]        spr_x_q, spr_x_n;
  logic [N_SPRITES-1:0]   mask_q, mask_n;
  logic [N_SPRITES-1:0]   eff_mask_q, eff_mask_n, eff_mask_c;
  logic [IDX_W-1:0]       i_q, i_n;
  logic [X_W-1:0]         x_q, x_n;
  logic [C_W-1:0]         cnt_x_q, cnt_x_n;
  logic [ROW_W-1:0]       y_q, y_n;
  logic [C_W-1:0]         cnt_y_q, cnt_y_n;
  logic [IDX_W-1:0]       spr_draw_n;
  logic                   busy_n, done_n;

  logic [SPR_W-1:0]       mem [FRAMES][SPR_H];
  logic [SPR_W-1:0]       row_bits;
  logic [X_W-1:0]         col;
  logic                   pix_bit;
  logic [N_SPRITES-1:0]   rem;
  logic                   pix_match;

`ifdef SPRITE_ROW_MIRROR_EN
  logic mirror_q, mirror_n;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
`endif

  // Screen x of sprite idx; wide enough that it never wraps.
  function automatic logic [POS_W-1:0] pos_of(input logic [PX_W-1:0]  sx,
                                              input logic [IDX_W-1:0] idx);
    return POS_W'(sx) + POS_W'(PITCH) * POS_W'(idx);
  endfunction

  // Bitmap storage: no reset, read-during-write returns the old line.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_frame][wr_row] <= wr_data;
  end

  // Sprites that are masked off or would run past the active line are hidden.
  always_comb begin
    eff_mask_c = '0;
    for (int unsigned k = 0; k < N_SPRITES; k++) begin
      eff_mask_c[k] = mask_q[k] &&
        ((pos_of(spr_x_q, IDX_W'(k)) + POS_W'(SPAN)) <= POS_W'(H_ACTIVE));
    end
  end

  // Current bitmap pixel and seek helpers.
  always_comb begin
    row_bits = mem[frame_q][y_q];
`ifdef SPRITE_ROW_MIRROR_EN
    col = mirror_q ? x_q : (X_W'(SPR_W - 1) - x_q);
`else
    col = X_W'(SPR_W - 1) - x_q;
`endif
    pix_bit   = row_bits[col];
    rem       = eff_mask_q >> i_q;
    pix_match = (POS_W'(pixel_x) == pos_of(spr_x_q, i_q));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_q;
    frame_n    = frame_q;
    spr_x_n    = spr_x_q;
    mask_n     = mask_q;
    eff_mask_n = eff_mask_q;
    i_n        = i_q;
    x_n        = x_q;
    cnt_x_n    = cnt_x_q;
    y_n        = y_q;
    cnt_y_n    = cnt_y_q;
    spr_draw_n = '0;
`ifdef SPRITE_ROW_MIRROR_EN
    mirror_n   = mirror_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_n = frame;
          spr_x_n = spr_x;
          mask_n  = mask;
`ifdef SPRITE_ROW_MIRROR_EN
          mirror_n = mirror;
`endif
          state_n = S_START;
        end
      end
      S_START: begin
        y_n        = '0;
        cnt_y_n    = '0;
        i_n        = '0;
        eff_mask_n = eff_mask_c;
        state_n    = S_SEEK;
      end
      S_SEEK: begin
        // rem[0] is the visibility of sprite i; rem==0 means nothing left on this line.
        if (rem == '0) begin
          state_n = S_NEXT_LINE;
        end else if (!rem[0]) begin
          i_n = i_q + IDX_W'(1);
        end else if (pix_match) begin
          x_n     = '0;
          cnt_x_n = '0;
          state_n = S_DRAW;
        end
      end
      S_DRAW: begin
        spr_draw_n = pix_bit ? (i_q + IDX_W'(1)) : '0;
        if (cnt_x_q == C_W'(SCALE - 1)) begin
          cnt_x_n = '0;
          if (x_q == X_W'(SPR_W - 1)) begin
            i_n     = i_q + IDX_W'(1);
            state_n = S_SEEK;
          end else begin
            x_n = x_q + X_W'(1);
          end
        end else begin
          cnt_x_n = cnt_x_q + C_W'(1);
        end
      end
      S_NEXT_LINE: begin
        i_n     = '0;
        state_n = S_SEEK;
        if (cnt_y_q == C_W'(SCALE - 1)) begin
          cnt_y_n = '0;
          if (y_q == ROW_W'(SPR_H - 1)) state_n = S_DONE;
          else                          y_n = y_q + ROW_W'(1);
        end else begin
          cnt_y_n = cnt_y_q + C_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n = (state_n == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      spr_x_q    <= '0;
      mask_q     <= '0;
      eff_mask_q <= '0;
      i_q        <= '0;
      x_q        <= '0;
      cnt_x_q    <= '0;
      y_q        <= '0;
      cnt_y_q    <= '0;
      spr_draw   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SPRITE_ROW_MIRROR_EN
      mirror_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      frame_q    <= frame_n;
      spr_x_q    <= spr_x_n;
      mask_q     <= mask_n;
      eff_mask_q <= eff_mask_n;
      i_q        <= i_n;
      x_q        <= x_n;
      cnt_x_q    <= cnt_x_n;
      y_q        <= y_n;
      cnt_y_q    <= cnt_y_n;
      spr_draw   <= spr_draw_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef SPRITE_ROW_MIRROR_EN
      mirror_q   <= mirror_n;
`endif
    end
  end

endmodule

// File: tb/tb_sprite_row_renderer.sv
`timescale 1ns/1ps
// Scoreboard bench for sprite_row_renderer with a free-running 640-column scan.
module tb_sprite_row_renderer;

  localparam int N     = 11;
  localparam int SW    = 13;
  localparam int SH    = 8;
  localparam int SC    = 3;
  localparam int PITCH = 48;
  localparam int HA    = 640;
  localparam int SPAN  = SW * SC;
  localparam int SCAN  = 640;
`ifdef SPRITE_ROW_MIRROR_EN
  localparam bit MIRROR_ON = 1'b1;
`else
  localparam bit MIRROR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [0:0]  frame;
  logic        mirror;
  logic [9:0]  spr_x;
  logic [10:0] mask;
  logic [9:0]  pixel_x;
  logic        wr_en;
  logic [0:0]  wr_frame;
  logic [2:0]  wr_row;
  logic [12:0] wr_data;
  logic [3:0]  spr_draw;
  logic        busy;
  logic        done;

  sprite_row_renderer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame(frame), .mirror(mirror),
    .spr_x(spr_x), .mask(mask), .pixel_x(pixel_x), .wr_en(wr_en),
    .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .spr_draw(spr_draw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int val;
    int col;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          h1 = 0;
  int          h2 = 0;
  logic [12:0] bmp [2][SH];

  // Horizontal scan: one column per clock, wraps at SCAN.
  initial begin
    pixel_x = '0;
    forever begin
      @(posedge clk);
      #1 pixel_x = (pixel_x == 10'(SCAN - 1)) ? 10'd0 : pixel_x + 10'd1;
    end
  end

  // Reference: every lit screen pixel of the row in scan order, then done.
  task automatic push_row(input int f, input logic [10:0] m, input int sx, input bit mir);
    exp_t e;
    bit   mir_eff;
    mir_eff = mir & MIRROR_ON;
    for (int ly = 0; ly < SH; ly++)
      for (int rep = 0; rep < SC; rep++)
        for (int s = 0; s < N; s++) begin
          int pos;
          pos = sx + PITCH * s;
          if (m[s] && (pos + SPAN <= HA))
            for (int c = 0; c < SPAN; c++) begin
              int bx, bi;
              bx = c / SC;
              bi = mir_eff ? bx : (SW - 1 - bx);
              if (bmp[f][ly][bi]) begin
                e.is_done = 1'b0; e.val = s + 1; e.col = pos + c;
                sb.push_back(e);
              end
            end
        end
    e.is_done = 1'b1; e.val = 0; e.col = 0;
    sb.push_back(e);
  endtask

  // Monitor: compares every nonzero spr_draw and every done pulse.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (spr_draw != 4'd0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pixel: got sprite %0d at col %0d, required no output", spr_draw, h2);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_done || int'(spr_draw) != e.val || h2 != e.col || !busy) begin
            errors++;
            $display("FAIL pixel: got sprite %0d col %0d busy %0b, required sprite %0d col %0d busy 1 (done_expected=%0b)",
                     spr_draw, h2, busy, e.val, e.col, e.is_done);
          end
        end
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done: got unexpected done pulse, required none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (!e.is_done || busy) begin
            errors++;
            $display("FAIL done: got done with busy %0b, required busy 0 and next expected sprite %0d col %0d",
                     busy, e.val, e.col);
          end
        end
      end
    end
    h2 = h1;
    h1 = int'(pixel_x);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic wr_line(input int f, input int r, input logic [12:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_frame = 1'(f); wr_row = 3'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    bmp[f][r] = d;
  endtask

  task automatic begin_row(input int f, input logic [10:0] m, input int sx, input bit mir);
    @(negedge clk);
    frame = 1'(f); mask = m; spr_x = 10'(sx); mirror = mir;
    push_row(f, m, sx, mir);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    // Scrambled inputs after start must not affect the row in flight.
    frame = 1'($urandom); mask = 11'($urandom); spr_x = 10'($urandom); mirror = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 20000 cycles, required done pulse", name);
    end
  endtask

  task automatic row_end(input string name);
    @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int sx;
    logic [10:0] m;
    rst_n = 1'b0; start = 1'b0; frame = '0; mirror = 1'b0; spr_x = '0; mask = '0;
    wr_en = 1'b0; wr_frame = '0; wr_row = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_spr_draw", int'(spr_draw), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    mon_en = 1'b1;

    wr_line(0, 0, 13'b1000000000001);
    for (int r = 1; r < SH; r++) wr_line(0, r, 13'($urandom));
    for (int r = 0; r < SH; r++) wr_line(1, r, 13'($urandom));

    // All sprites, spr_x=10.
    begin_row(0, 11'h7FF, 10, 1'b0);
    wait_done("all_row");
    row_end("all_row_empty");

    // Asymmetric line 0, sprites 0 and 2 only, mirror requested.
    wr_line(0, 0, 13'b1100000000000);
    begin_row(0, 11'b00000000101, 0, 1'b1);
    wait_done("mask101_row");
    row_end("mask101_empty");

    // Right-edge row: only sprite 0 fits.
    begin_row(0, 11'h7FF, 600, 1'b0);
    wait_done("edge_row");
    row_end("edge_empty");

    // Empty mask; start held through the done cycle into the first idle cycle.
    begin_row(0, 11'h000, 100, 1'b0);
    wait_done("mask0_row");
    frame = 1'b0; mask = 11'h000; spr_x = 10'd5; mirror = 1'b0;
    push_row(0, 11'h000, 5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    check("busy_after_done_start", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("busy_idle_start", int'(busy), 1);
    wait_done("mask0_row_b");
    row_end("mask0_empty");

    // Random frame-1 row with a start while busy and concurrent frame-0 writes.
    m  = 11'($urandom) | 11'd1;
    sx = $urandom_range(0, 601);
    begin_row(1, m, sx, 1'($urandom));
    fork
      begin
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(50, 800)) @(negedge clk);
          wr_line(0, $urandom_range(0, SH - 1), 13'($urandom));
        end
      end
      wait_done("rand_row");
    join
    row_end("rand_empty");

    // Asynchronous reset in the middle of drawing.
    begin_row(0, 11'h7FF, 10, 1'b0);
    n = 0;
    while (spr_draw == 4'd0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_draw", int'(n < 5000), 1);
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrow_reset_spr_draw", int'(spr_draw), 0);
    check("midrow_reset_busy", int'(busy), 0);
    check("midrow_reset_done", int'(done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy || spr_draw != 4'd0) seen = 1;
    end
    check("no_activity_after_reset", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
